branch_resolve_unit: RTL and testbench

//  Consumer end of the direction predictor interface. Carries the D-stage prediction (pred_takeD) and

---
 rtl/branch_resolve_unit.sv | 102 ++++++++++
 tb/tb_branch_resolve_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries D-stage branch predictions to M, resolves them, and drives predictor update, redirect and perf counters
module branch_resolve_unit #(
  parameter logic [31:0] FALL_OFFSET = 32'd8,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branchD,
  input  logic                 pred_takeD,
  input  logic [31:0]          pcD,
  input  logic [31:0]          targetD,
  input  logic                 actual_takeE,
  input  logic                 stallE,
  input  logic                 stallM,
  input  logic                 flushE,
  input  logic                 flushM,
  input  logic                 stallF,
  output logic                 branchM,
  output logic                 actual_takeM,
  output logic [31:0]          pcM,
  output logic                 errorM,
  output logic                 flush_req,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] br_cnt,
  output logic [CNT_WIDTH-1:0] mis_cnt
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state, w_state_next;
  logic        r_branchE, r_predE, r_branchM, r_predM, r_actualM;
  logic [31:0] r_pcE, r_targetE, r_pcM, r_targetM, r_pend_pc;
  logic [CNT_WIDTH-1:0] r_br_cnt, r_mis_cnt;
  logic        w_resolve, w_error;
  logic [31:0] w_target;
  assign w_resolve      = r_branchM & ~stallM;
  assign w_error        = w_resolve & (r_predM != r_actualM);
  assign w_target       = r_actualM ? r_targetM : r_pcM + FALL_OFFSET;
  assign branchM        = r_branchM;
  assign actual_takeM   = r_actualM;
  assign pcM            = r_pcM;
  assign errorM         = w_error;
  assign flush_req      = w_error;
  assign br_cnt         = r_br_cnt;
  assign mis_cnt        = r_mis_cnt;
  // D->E pipe register; flush clears it even when stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst | flushE) begin
      r_branchE <= 1'b0;
      r_predE   <= 1'b0;
      r_pcE     <= '0;
      r_targetE <= '0;
    end else if (~stallE) begin
      r_branchE <= branchD;
      r_predE   <= pred_takeD;
      r_pcE     <= pcD;
      r_targetE <= targetD;
    end
  end
  // E->M pipe register, picks up the evaluated direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst | flushM) begin
      r_branchM <= 1'b0;
      r_predM   <= 1'b0;
      r_actualM <= 1'b0;
      r_pcM     <= '0;
      r_targetM <= '0;
    end else if (~stallM) begin
      r_branchM <= r_branchE;
      r_predM   <= r_predE;
      r_actualM <= actual_takeE;
      r_pcM     <= r_pcE;
      r_targetM <= r_targetE;
    end
  end
  // redirect state and pending PC; the newest mispredict always overwrites
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pend_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_error & stallF) r_pend_pc <= w_target;
    end
  end
  // hold the redirect while fetch is stalled, drive a fresh one immediately
  always_comb begin
    w_state_next   = IDLE;
    redirect_valid = w_error | (r_state == HOLD);
    redirect_pc    = w_error ? w_target : (r_state == HOLD) ? r_pend_pc : '0;
    if ((w_error | (r_state == HOLD)) & stallF) w_state_next = HOLD;
  end
  // saturating branch and mispredict counters, updated once per resolved branch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_resolve) begin
      r_br_cnt <= &r_br_cnt ? r_br_cnt : r_br_cnt + CNT_WIDTH'(1);
      if (w_error) r_mis_cnt <= &r_mis_cnt ? r_mis_cnt : r_mis_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        branchD = 0, pred_takeD = 0, actual_takeE = 0;
  logic        stallE = 0, stallM = 0, flushE = 0, flushM = 0, stallF = 0;
  logic [31:0] pcD = '0, targetD = '0;
  logic        branchM, actual_takeM, errorM, flush_req, redirect_valid;
  logic [31:0] pcM, redirect_pc;
  logic [3:0]  br_cnt, mis_cnt;
  int checks = 0, errors = 0;

  branch_resolve_unit #(.FALL_OFFSET(32'd8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD),
    .targetD(targetD), .actual_takeE(actual_takeE), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushM(flushM), .stallF(stallF), .branchM(branchM),
    .actual_takeM(actual_takeM), .pcM(pcM), .errorM(errorM), .flush_req(flush_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue one branch at D, evaluate it in E, return 1ns into its M cycle
  task automatic br(input logic [31:0] pc, input logic [31:0] tgt, input logic pred, input logic act);
    branchD = 1; pcD = pc; targetD = tgt; pred_takeD = pred;
    step();
    branchD = 0; actual_takeE = act;
    step();
    actual_takeE = 0;
    #1;
  endtask

  initial begin
    #2;
    chk("rst_branchM", branchM, 0);
    chk("rst_pcM", pcM, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_mis_cnt", mis_cnt, 0);
    step(); step();
    rst = 0;
    step();
    // correct prediction, taken
    br(32'h100, 32'h200, 1, 1);
    chk("t1_branchM", branchM, 1);
    chk("t1_pcM", pcM, 32'h100);
    chk("t1_actual", actual_takeM, 1);
    chk("t1_errorM", errorM, 0);
    chk("t1_redirect_valid", redirect_valid, 0);
    step();
    chk("t1_br_cnt", br_cnt, 1);
    chk("t1_mis_cnt", mis_cnt, 0);
    chk("t1_branchM_after", branchM, 0);
    // predicted not-taken, actually taken
    br(32'h100, 32'h200, 0, 1);
    chk("t2_errorM", errorM, 1);
    chk("t2_flush_req", flush_req, 1);
    chk("t2_redirect_valid", redirect_valid, 1);
    chk("t2_redirect_pc", redirect_pc, 32'h200);
    step();
    chk("t2_redirect_gone", redirect_valid, 0);
    chk("t2_br_cnt", br_cnt, 2);
    chk("t2_mis_cnt", mis_cnt, 1);
    // predicted taken, actually not taken: fall-through redirect
    br(32'h100, 32'h200, 1, 0);
    chk("t3_redirect_valid", redirect_valid, 1);
    chk("t3_redirect_pc", redirect_pc, 32'h108);
    step();
    chk("t3_redirect_gone", redirect_valid, 0);
    br(32'hFFFF_FFFC, 32'h40, 1, 0);
    chk("t3_wrap_pc", redirect_pc, 32'h4);
    step();
    chk("t3_br_cnt", br_cnt, 4);
    chk("t3_mis_cnt", mis_cnt, 3);
    // mispredict while fetch is stalled for three cycles
    stallF = 1;
    br(32'h300, 32'h500, 0, 1);
    chk("t4_c0_valid", redirect_valid, 1);
    chk("t4_c0_pc", redirect_pc, 32'h500);
    step();
    chk("t4_c1_valid", redirect_valid, 1);
    chk("t4_c1_pc", redirect_pc, 32'h500);
    chk("t4_c1_errorM", errorM, 0);
    step();
    chk("t4_c2_valid", redirect_valid, 1);
    chk("t4_c2_pc", redirect_pc, 32'h500);
    stallF = 0;
    #1;
    chk("t4_c3_valid", redirect_valid, 1);
    chk("t4_c3_pc", redirect_pc, 32'h500);
    step();
    chk("t4_done_valid", redirect_valid, 0);
    chk("t4_done_pc", redirect_pc, 0);
    chk("t4_br_cnt", br_cnt, 5);
    chk("t4_mis_cnt", mis_cnt, 4);
    // M stalled with a mispredicting branch: resolved only after release
    br(32'h400, 32'h600, 1, 0);
    stallM = 1;
    #1;
    chk("t5_stall_branchM", branchM, 1);
    chk("t5_stall_errorM", errorM, 0);
    chk("t5_stall_flush", flush_req, 0);
    chk("t5_stall_valid", redirect_valid, 0);
    step();
    chk("t5_stall2_errorM", errorM, 0);
    chk("t5_stall_br_cnt", br_cnt, 5);
    step();
    stallM = 0;
    #1;
    chk("t5_rel_errorM", errorM, 1);
    chk("t5_rel_pc", redirect_pc, 32'h408);
    step();
    chk("t5_rel_errorM_once", errorM, 0);
    chk("t5_br_cnt", br_cnt, 6);
    chk("t5_mis_cnt", mis_cnt, 5);
    // flushM together with a valid branch in E
    branchD = 1; pcD = 32'h500; targetD = 32'h700; pred_takeD = 0;
    step();
    branchD = 0; flushM = 1; actual_takeE = 1;
    step();
    flushM = 0; actual_takeE = 0;
    #1;
    chk("t5_flush_branchM", branchM, 0);
    chk("t5_flush_valid", redirect_valid, 0);
    step();
    chk("t5_flush_br_cnt", br_cnt, 6);
    // saturate br_cnt with 12 correct branches, then mis_cnt with 12 mispredicts
    branchD = 1; pred_takeD = 1; actual_takeE = 1; pcD = 32'h800; targetD = 32'h900;
    repeat (12) step();
    branchD = 0;
    repeat (3) step();
    actual_takeE = 0;
    chk("t6_br_sat", br_cnt, 4'hF);
    chk("t6_mis_hold", mis_cnt, 5);
    branchD = 1; pred_takeD = 0; actual_takeE = 1;
    repeat (12) step();
    branchD = 0;
    repeat (3) step();
    actual_takeE = 0;
    chk("t6_br_still_sat", br_cnt, 4'hF);
    chk("t6_mis_sat", mis_cnt, 4'hF);
    // asynchronous reset while holding a redirect
    stallF = 1;
    br(32'hA00, 32'hB00, 0, 1);
    step();
    chk("t6_hold_valid", redirect_valid, 1);
    chk("t6_hold_pc", redirect_pc, 32'hB00);
    #2 rst = 1;
    #1;
    chk("t6_arst_valid", redirect_valid, 0);
    chk("t6_arst_pc", redirect_pc, 0);
    chk("t6_arst_br_cnt", br_cnt, 0);
    chk("t6_arst_mis_cnt", mis_cnt, 0);
    chk("t6_arst_pcM", pcM, 0);
    step();
    stallF = 0; rst = 0;
    step();
    chk("t6_post_valid", redirect_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
